// File: rtl/rx_fifo_ctrl.sv
// rx_fifo_ctrl: UART-16550 receive FIFO with per-character error flags,
// LSR receive bits and the three receive interrupt sources.
module rx_fifo_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          baud_tick,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rx_pe,
    input  logic          rx_fe,
    input  logic [7:0]    lcr,
    input  logic          fifo_en,
    input  logic          fifo_clr,
    input  logic [1:0]    trig,
    input  logic          rd_en,
    input  logic          lsr_rd,
    output logic [7:0]    rd_data,
    output logic          dr,
    output logic          oe,
    output logic          pe,
    output logic          fe,
    output logic          fifo_err,
    output logic [AW:0]   level,
    output logic          irq_rda,
    output logic          irq_rls,
    output logic          irq_cto
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [AW:0]   err_cnt_q, err_cnt_d;
    logic          oe_q, oe_d;
    logic          fifo_en_q, fifo_en_d;
    logic [5:0]    tmo_q, tmo_d;
    logic          rda_q, rda_d;
    logic          cto_q, cto_d;

    logic [9:0]    head;
    logic [9:0]    wr_entry;
    logic          head_err, new_err;
    logic          clr, empty, full;
    logic          do_pop, do_push, ovr, ovwr;
    logic [3:0]    char_bits;
    logic [5:0]    tmo_thr;
    logic [AW:0]   trig_lvl;
    logic          unused_lcr;

    assign unused_lcr = ^lcr[7:4];

    always_comb begin
        head     = mem_q[rd_ptr_q];
        wr_entry = {rx_fe, rx_pe, rx_data};
        head_err = head[9] | head[8];
        new_err  = rx_fe | rx_pe;
        // A mode change flushes the queue just like an explicit clear.
        clr      = fifo_clr | (fifo_en != fifo_en_q);
        empty    = (level_q == '0);
        full     = fifo_en_q ? (level_q == LVL_FULL) : !empty;
        do_pop   = rd_en & !empty & !clr;
        do_push  = rx_valid & !clr & (!full | do_pop);
        ovr      = rx_valid & !clr & full & !do_pop;
        ovwr     = ovr & !fifo_en_q;
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            level_d   = '0;
            err_cnt_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                level_d  = level_d + LVL_ONE;
                if (new_err) err_cnt_d = err_cnt_d + LVL_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                level_d  = level_d - LVL_ONE;
                if (head_err) err_cnt_d = err_cnt_d - LVL_ONE;
            end
            // 16450 overwrite: the single entry is the whole error count.
            if (ovwr) err_cnt_d = {{AW{1'b0}}, new_err};
        end
    end

    always_comb begin
        fifo_en_d = fifo_en;
        oe_d      = ovr ? 1'b1 : (lsr_rd ? 1'b0 : oe_q);
        char_bits = 4'd7 + {2'b00, lcr[1:0]} + {3'b000, lcr[3]}
                  + {3'b000, lcr[2]};
        tmo_thr   = {char_bits, 2'b00};
        tmo_d     = tmo_q;
        if (clr | rx_valid | do_pop | empty) begin
            tmo_d = '0;
        end else if (baud_tick & fifo_en_q & (tmo_q != 6'h3f)) begin
            tmo_d = tmo_q + 6'd1;
        end
        cto_d = (tmo_d >= tmo_thr);
        unique case (trig)
            2'b00:   trig_lvl = (AW+1)'(1);
            2'b01:   trig_lvl = (AW+1)'(4);
            2'b10:   trig_lvl = (AW+1)'(8);
            default: trig_lvl = (AW+1)'(14);
        endcase
        rda_d = fifo_en ? (level_d >= trig_lvl) : (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end else if (ovwr) begin
            mem_q[rd_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            err_cnt_q <= '0;
            oe_q      <= 1'b0;
            fifo_en_q <= 1'b0;
            tmo_q     <= '0;
            rda_q     <= 1'b0;
            cto_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            err_cnt_q <= err_cnt_d;
            oe_q      <= oe_d;
            fifo_en_q <= fifo_en_d;
            tmo_q     <= tmo_d;
            rda_q     <= rda_d;
            cto_q     <= cto_d;
        end
    end

    assign dr       = !empty;
    assign rd_data  = empty ? 8'h00 : head[7:0];
    assign pe       = !empty & head[8];
    assign fe       = !empty & head[9];
    assign oe       = oe_q;
    assign fifo_err = fifo_en_q & (err_cnt_q != '0);
    assign level    = level_q;
    assign irq_rda  = rda_q;
    assign irq_rls  = oe_q | pe | fe;
    assign irq_cto  = cto_q;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// tb_rx_fifo_ctrl: vector table for queue/flag behaviour plus
// scoreboard-driven sequences for overrun, timeout, clear and reset.
module tb_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_pe = 1'b0;
    logic       rx_fe = 1'b0;
    logic [7:0] lcr = 8'h03;
    logic       fifo_en = 1'b0;
    logic       fifo_clr = 1'b0;
    logic [1:0] trig = 2'b00;
    logic       rd_en = 1'b0;
    logic       lsr_rd = 1'b0;

    logic [7:0] rd_data;
    logic       dr, oe, pe, fe, fifo_err;
    logic [4:0] level;
    logic       irq_rda, irq_rls, irq_cto;

    int total = 0;
    int bad = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       r;
        logic [4:0] lvl;
        logic [7:0] dat;
        logic [7:0] flg;
    } vec_t;

    vec_t tbl[16];

    rx_fifo_ctrl #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_pe(rx_pe), .rx_fe(rx_fe), .lcr(lcr),
        .fifo_en(fifo_en), .fifo_clr(fifo_clr), .trig(trig),
        .rd_en(rd_en), .lsr_rd(lsr_rd), .rd_data(rd_data),
        .dr(dr), .oe(oe), .pe(pe), .fe(fe), .fifo_err(fifo_err),
        .level(level), .irq_rda(irq_rda), .irq_rls(irq_rls),
        .irq_cto(irq_cto)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // flag order: dr oe pe fe fifo_err irq_rda irq_rls irq_cto
    function automatic logic [7:0] flags();
        return {dr, oe, pe, fe, fifo_err, irq_rda, irq_rls, irq_cto};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d,
                        input logic p, input logic f,
                        input logic r, input logic l);
        rx_valid = v;
        rx_data  = d;
        rx_pe    = p;
        rx_fe    = f;
        rd_en    = r;
        lsr_rd   = l;
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        rx_pe     = 1'b0;
        rx_fe     = 1'b0;
        rd_en     = 1'b0;
        lsr_rd    = 1'b0;
        fifo_clr  = 1'b0;
        baud_tick = 1'b0;
    endtask

    task automatic push_sb(input logic [7:0] d);
        sb.push_back(d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_sb();
        logic [7:0] e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            chk("sb_data", 32'(rd_data), 32'(e));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            baud_tick = 1'b1;
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 5'd1, 8'h41, 8'h80};
        tbl[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 5'd2, 8'h41, 8'h80};
        tbl[2]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 5'd3, 8'h41, 8'h80};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 5'd4, 8'h41, 8'h84};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd3, 8'h42, 8'h80};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, 8'h43, 8'h80};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 8'h44, 8'h80};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 8'h00};
        tbl[8]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 5'd1, 8'h55, 8'hAA};
        tbl[9]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 5'd2, 8'h55, 8'hAA};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 8'h66, 8'h80};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 8'h00};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 8'h00};
        tbl[13] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 5'd1, 8'h77, 8'h9A};
        tbl[14] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 5'd1, 8'h88, 8'h80};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_data", 32'(rd_data), 32'h00);
        chk("rst_flags", 32'(flags()), 32'h00);
        rst_n = 1'b1;

        fifo_en = 1'b1;
        trig = 2'b01;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].f, tbl[i].r, 1'b0);
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(tbl[i].dat));
            chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(tbl[i].flg));
        end

        trig = 2'b11;
        for (int i = 0; i < 16; i++) push_sb(8'(8'h10 + i));
        chk("full_level", 32'(level), 32'd16);
        chk("full_flags", 32'(flags()), 32'h84);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_oe", 32'(oe), 32'd1);
        chk("ovr_level", 32'(level), 32'd16);
        step(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_lsr_oe", 32'(oe), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lsr_clr_oe", 32'(oe), 32'd0);
        chk("full_pp_head", 32'(rd_data), 32'(sb.pop_front()));
        sb.push_back(8'hBB);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_pp_level", 32'(level), 32'd16);
        chk("full_pp_oe", 32'(oe), 32'd0);
        for (int i = 0; i < 16; i++) read_sb();
        chk("drain_dr", 32'(dr), 32'd0);

        lcr = 8'h03;
        push_sb(8'h5A);
        ticks(39);
        chk("cto_39", 32'(irq_cto), 32'd0);
        ticks(1);
        chk("cto_40", 32'(irq_cto), 32'd1);
        read_sb();
        chk("cto_rd", 32'(irq_cto), 32'd0);
        push_sb(8'h61);
        ticks(39);
        push_sb(8'h62);
        ticks(39);
        chk("cto_restart", 32'(irq_cto), 32'd0);
        ticks(1);
        chk("cto_restart40", 32'(irq_cto), 32'd1);
        read_sb();
        chk("cto_pop", 32'(irq_cto), 32'd0);
        read_sb();

        push_sb(8'h71);
        push_sb(8'h72);
        chk("pre_clr_level", 32'(level), 32'd2);
        fifo_clr = 1'b1;
        step(1'b1, 8'h73, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.delete();
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_flags", 32'(flags()), 32'h00);

        fifo_en = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nf_level1", 32'(level), 32'd1);
        chk("nf_data1", 32'(rd_data), 32'h11);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nf_data2", 32'(rd_data), 32'h22);
        chk("nf_level2", 32'(level), 32'd1);
        chk("nf_flags", 32'(flags()), 32'hC6);

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_data", 32'(rd_data), 32'h00);
        chk("arst_flags", 32'(flags()), 32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_level", 32'(level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
